// File: rtl/ipsxe_floating_point_axis_result_checker_if.sv
// AXI4-Stream result channel carrying floating-point beats from the core to the checker.
interface ipsxe_floating_point_axis_result_checker_if #(
  parameter int unsigned DW = 32
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/ipsxe_floating_point_axis_result_checker.sv
// Checks the core's AXI4-Stream result beats against an expected-result ROM,
// with programmable tready backpressure, saturating error count and handshake timeout.
module ipsxe_floating_point_axis_result_checker #(
  parameter int unsigned EXP_W     = 8,
  parameter int unsigned MAN_W     = 23,
  parameter int unsigned NUM_BEATS = 10,
  parameter int unsigned ADDR_W    = 4,
  parameter logic [7:0]  READY_PAT = 8'b1111_1111,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  ipsxe_floating_point_axis_result_checker_if.slave s_axis,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [EXP_W+MAN_W:0] rom_data,
  input  logic                 rom_last,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [7:0]           err_cnt,
  output logic [ADDR_W:0]      beat_cnt
);

  localparam int unsigned DW   = 1 + EXP_W + MAN_W;
  localparam int unsigned BW   = ADDR_W + 1;
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0]   LAST_BEAT = BW'(NUM_BEATS - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ACCEPT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        pattern_q, pattern_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  logic [ADDR_W-1:0] addr_d;
  logic              ready_d;
  logic              busy_d;
  logic              done_d;
  logic              pass_d;
  logic              timeout_d;
  logic [7:0]        err_d;
  logic [BW-1:0]     beat_d;

  logic              hs;
  logic              mismatch;
  logic [7:0]        err_sat;
  logic [7:0]        pat_rot;

  // NaN: exponent all ones with a nonzero mantissa; sign and payload are irrelevant.
  function automatic logic is_nan(input logic [DW-1:0] v);
    return (&v[DW-2:MAN_W]) && (|v[MAN_W-1:0]);
  endfunction

  // Beat comparison and saturating error update.
  always_comb begin
    hs       = s_axis.tvalid && s_axis.tready;
    mismatch = (s_axis.tlast != rom_last) ||
               ((s_axis.tdata != rom_data) && !(is_nan(s_axis.tdata) && is_nan(rom_data)));
    err_sat  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'(mismatch);
    pat_rot  = {pattern_q[0], pattern_q[7:1]};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    to_cnt_d  = to_cnt_q;
    addr_d    = rom_addr;
    ready_d   = 1'b0;
    busy_d    = busy;
    done_d    = done;
    pass_d    = pass;
    timeout_d = timeout;
    err_d     = err_cnt;
    beat_d    = beat_cnt;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = FETCH;
          pattern_d = READY_PAT;
          to_cnt_d  = '0;
          addr_d    = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          err_d     = '0;
          beat_d    = '0;
        end
      end

      FETCH: begin
        // ROM output settles this cycle; tready for the first ACCEPT cycle is set up here.
        state_d = ACCEPT;
        ready_d = pattern_q[0];
      end

      ACCEPT: begin
        pattern_d = pat_rot;
        if (hs) begin
          err_d    = err_sat;
          beat_d   = beat_cnt + 1'b1;
          to_cnt_d = '0;
          if (beat_cnt == LAST_BEAT) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_sat == 8'd0);
          end else begin
            state_d = FETCH;
            addr_d  = rom_addr + 1'b1;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_q == TO_LAST) begin
            state_d   = DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            pass_d    = 1'b0;
            timeout_d = 1'b1;
          end
        end
        if (state_d == ACCEPT) begin
          ready_d = pat_rot[0];
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pattern_q     <= READY_PAT;
      to_cnt_q      <= '0;
      rom_addr      <= '0;
      s_axis.tready <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      err_cnt       <= '0;
      beat_cnt      <= '0;
    end else begin
      state_q       <= state_d;
      pattern_q     <= pattern_d;
      to_cnt_q      <= to_cnt_d;
      rom_addr      <= addr_d;
      s_axis.tready <= ready_d;
      busy          <= busy_d;
      done          <= done_d;
      pass          <= pass_d;
      timeout       <= timeout_d;
      err_cnt       <= err_d;
      beat_cnt      <= beat_d;
    end
  end

endmodule

// File: tb/tb_ipsxe_floating_point_axis_result_checker.sv
// Bench for the AXI4-Stream result checker: directed streams, a mismatch-rule table,
// backpressure, timeout, reset/start robustness, saturation and randomized runs.
module tb_ipsxe_floating_point_axis_result_checker;

  localparam logic [7:0] PAT_B = 8'b0000_0101;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance A: 10 beats, all-ones pattern, short timeout
  ipsxe_floating_point_axis_result_checker_if #(.DW(32)) a_if();
  logic        a_start;
  logic [3:0]  a_addr;
  logic [31:0] a_rom_d;
  logic        a_rom_l;
  logic        a_busy, a_done, a_pass, a_to;
  logic [7:0]  a_err;
  logic [4:0]  a_beat;

  ipsxe_floating_point_axis_result_checker #(
    .EXP_W(8), .MAN_W(23), .NUM_BEATS(10), .ADDR_W(4), .READY_PAT(8'hFF), .TIMEOUT(15)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .s_axis(a_if),
    .rom_addr(a_addr), .rom_data(a_rom_d), .rom_last(a_rom_l),
    .busy(a_busy), .done(a_done), .pass(a_pass), .timeout(a_to),
    .err_cnt(a_err), .beat_cnt(a_beat)
  );

  // ---------------- instance B: sparse tready pattern
  ipsxe_floating_point_axis_result_checker_if #(.DW(32)) b_if();
  logic        b_start;
  logic [3:0]  b_addr;
  logic [31:0] b_rom_d;
  logic        b_rom_l;
  logic        b_busy, b_done, b_pass, b_to;
  logic [7:0]  b_err;
  logic [4:0]  b_beat;

  ipsxe_floating_point_axis_result_checker #(
    .EXP_W(8), .MAN_W(23), .NUM_BEATS(10), .ADDR_W(4), .READY_PAT(PAT_B), .TIMEOUT(15)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .s_axis(b_if),
    .rom_addr(b_addr), .rom_data(b_rom_d), .rom_last(b_rom_l),
    .busy(b_busy), .done(b_done), .pass(b_pass), .timeout(b_to),
    .err_cnt(b_err), .beat_cnt(b_beat)
  );

  // ---------------- instance C: 300 beats for saturation
  ipsxe_floating_point_axis_result_checker_if #(.DW(32)) c_if();
  logic        c_start;
  logic [8:0]  c_addr;
  logic [31:0] c_rom_d;
  logic        c_rom_l;
  logic        c_busy, c_done, c_pass, c_to;
  logic [7:0]  c_err;
  logic [9:0]  c_beat;

  ipsxe_floating_point_axis_result_checker #(
    .EXP_W(8), .MAN_W(23), .NUM_BEATS(300), .ADDR_W(9), .READY_PAT(8'hFF), .TIMEOUT(15)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .s_axis(c_if),
    .rom_addr(c_addr), .rom_data(c_rom_d), .rom_last(c_rom_l),
    .busy(c_busy), .done(c_done), .pass(c_pass), .timeout(c_to),
    .err_cnt(c_err), .beat_cnt(c_beat)
  );

  // ---------------- ROM models (1-cycle read latency) and stimulus storage
  logic [31:0] base_d [16];
  logic        base_l [16];
  logic [31:0] rom_a_d [16];
  logic        rom_a_l [16];
  logic [31:0] tx_d [16];
  logic        tx_l [16];
  int          exp_m [16];

  function automatic logic [31:0] rom_c_word(input logic [8:0] a);
    return 32'h3F00_0000 | 32'(a);
  endfunction

  always @(posedge clk) begin
    a_rom_d <= rom_a_d[a_addr];
    a_rom_l <= rom_a_l[a_addr];
    b_rom_d <= base_d[b_addr];
    b_rom_l <= base_l[b_addr];
    c_rom_d <= rom_c_word(c_addr);
    c_rom_l <= (c_addr == 9'd299);
  end

  typedef struct {
    logic [31:0] exp_d;
    logic        exp_l;
    logic [31:0] rx_d;
    logic        rx_l;
    int          mism;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference mismatch rule, computed from decoded IEEE-754 single fields.
  function automatic int ref_mismatch(input logic [31:0] e, input logic el,
                                      input logic [31:0] r, input logic rl);
    int unsigned ee, re, em, rm;
    bit en, rn;
    ee = (e >> 23) & 32'hFF;  em = e & 32'h7F_FFFF;
    re = (r >> 23) & 32'hFF;  rm = r & 32'h7F_FFFF;
    en = (ee == 255) && (em != 0);
    rn = (re == 255) && (rm != 0);
    if (el != rl) return 1;
    if (en && rn) return 0;
    return (e != r) ? 1 : 0;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [22:0] m;
    logic        s;
    m = 23'($urandom);
    s = 1'($urandom);
    case ($urandom_range(4, 0))
      0:       return {s, 8'hFF, (m == 23'd0) ? 23'd1 : m};
      1:       return {s, 31'd0};
      2:       return {s, 8'hFF, 23'd0};
      default: return $urandom;
    endcase
  endfunction

  task automatic pulse_start_a();
    @(negedge clk);
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  // Drives tx_* into instance A. Iteration 0 is the FETCH cycle after start.
  task automatic drive_a(input int n_offer, input bit stop_at_n, input bit rand_valid,
                         input int start_at, output int acc_first, output int done_at,
                         output int last_hs);
    int idx;
    int exp_err;
    bit hs;
    idx = 0; exp_err = 0; acc_first = -1; done_at = -1; last_hs = -1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (a_done) begin
        done_at = c;
        break;
      end
      if (acc_first < 0 && a_if.tready) acc_first = c;
      a_start     = (c == start_at);
      a_if.tvalid = (idx < n_offer) && (!rand_valid || $urandom_range(3, 0) != 0);
      a_if.tdata  = tx_d[idx];
      a_if.tlast  = tx_l[idx];
      hs = a_if.tvalid && a_if.tready;
      @(posedge clk); #1;
      if (hs) begin
        exp_err = (exp_err + exp_m[idx] > 255) ? 255 : exp_err + exp_m[idx];
        idx++;
        last_hs = c;
        check("a_beat_cnt_step", 64'(a_beat), 64'(idx));
        check("a_err_cnt_step", 64'(a_err), 64'(exp_err));
        if (stop_at_n && idx == n_offer) break;
      end
    end
    a_start     = 1'b0;
    a_if.tvalid = 1'b0;
    if (!stop_at_n) check("a_done_within_budget", 64'(done_at >= 0), 64'd1);
  endtask

  task automatic check_end_a(input string tag, input int beats, input int errs,
                             input bit ps, input bit to);
    check({tag, "_done"}, 64'(a_done), 64'd1);
    check({tag, "_busy"}, 64'(a_busy), 64'd0);
    check({tag, "_beat_cnt"}, 64'(a_beat), 64'(beats));
    check({tag, "_err_cnt"}, 64'(a_err), 64'(errs));
    check({tag, "_pass"}, 64'(a_pass), 64'(ps));
    check({tag, "_timeout"}, 64'(a_to), 64'(to));
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_rom_addr"}, 64'(a_addr), 64'd0);
    check({tag, "_tready"}, 64'(a_if.tready), 64'd0);
    check({tag, "_busy"}, 64'(a_busy), 64'd0);
    check({tag, "_done"}, 64'(a_done), 64'd0);
    check({tag, "_pass"}, 64'(a_pass), 64'd0);
    check({tag, "_timeout"}, 64'(a_to), 64'd0);
    check({tag, "_err_cnt"}, 64'(a_err), 64'd0);
    check({tag, "_beat_cnt"}, 64'(a_beat), 64'd0);
  endtask

  task automatic load_base();
    for (int i = 0; i < 16; i++) begin
      rom_a_d[i] = base_d[i]; rom_a_l[i] = base_l[i];
      tx_d[i] = base_d[i];    tx_l[i] = base_l[i];
      exp_m[i] = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_first, done_at, last_hs, k, beats, exp_sum;
    bit fetch, exp_r, hs;

    base_d = '{32'h4000_0000, 32'hBF80_0000, 32'h0000_0000, 32'h3F80_0000,
               32'h7F80_0000, 32'hC2C8_0000, 32'h3E99_999A, 32'h4120_0000,
               32'h8000_0000, 32'h7FC0_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 16; i++) base_l[i] = (i == 7) || (i == 9);

    tbl[0] = '{32'h7FC0_0000, 1'b0, 32'hFFC0_0001, 1'b0, 0};
    tbl[1] = '{32'h0000_0000, 1'b0, 32'h8000_0000, 1'b0, 1};
    tbl[2] = '{32'h7F80_0000, 1'b0, 32'h7FC0_0000, 1'b0, 1};
    tbl[3] = '{32'h7F80_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 0};
    tbl[4] = '{32'hFF80_0000, 1'b0, 32'h7F80_0000, 1'b0, 1};
    tbl[5] = '{32'h3F80_0000, 1'b0, 32'h3F80_0000, 1'b1, 1};
    tbl[6] = '{32'h7FC0_0000, 1'b1, 32'h7FC0_0000, 1'b0, 1};
    tbl[7] = '{32'h7F80_0000, 1'b0, 32'h7F80_0000, 1'b0, 0};
    tbl[8] = '{32'h7FC0_0000, 1'b0, 32'h7F80_0000, 1'b0, 1};
    tbl[9] = '{32'h4049_0FDB, 1'b1, 32'h4049_0FDB, 1'b1, 0};

    rst_n = 1'b0;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_if.tvalid = 1'b0; a_if.tdata = '0; a_if.tlast = 1'b0;
    b_if.tvalid = 1'b0; b_if.tdata = '0; b_if.tlast = 1'b0;
    c_if.tvalid = 1'b0; c_if.tdata = '0; c_if.tlast = 1'b0;
    load_base();
    repeat (3) @(posedge clk);
    #1;
    check_reset_a("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Clean stream: 20 cycles from first ACCEPT cycle through first DONE cycle, inclusive.
    pulse_start_a();
    check("t1_busy_after_start", 64'(a_busy), 64'd1);
    check("t1_tready_in_fetch", 64'(a_if.tready), 64'd0);
    drive_a(10, 1'b0, 1'b0, -1, acc_first, done_at, last_hs);
    check_end_a("t1", 10, 0, 1'b1, 1'b0);
    check("t1_first_accept_iter", 64'(acc_first), 64'd1);
    check("t1_accept_to_done_cycles", 64'(done_at - acc_first + 1), 64'd20);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_if.tvalid = 1'b1;
      check("t1_tready_in_done", 64'(a_if.tready), 64'd0);
      @(posedge clk); #1;
      check("t1_beat_hold_in_done", 64'(a_beat), 64'd10);
    end
    a_if.tvalid = 1'b0;

    // Corrupted data on beat 3 and dropped tlast on beat 7.
    load_base();
    tx_d[3] = 32'h3F80_0001; exp_m[3] = 1;
    tx_l[7] = 1'b0;          exp_m[7] = 1;
    pulse_start_a();
    check("t2_err_cleared_on_start", 64'(a_err), 64'd0);
    drive_a(10, 1'b0, 1'b0, -1, acc_first, done_at, last_hs);
    check_end_a("t2", 10, 2, 1'b0, 1'b0);

    // Table of comparison-rule vectors applied as one run.
    exp_sum = 0;
    for (int i = 0; i < 10; i++) begin
      rom_a_d[i] = tbl[i].exp_d; rom_a_l[i] = tbl[i].exp_l;
      tx_d[i]    = tbl[i].rx_d;  tx_l[i]    = tbl[i].rx_l;
      exp_m[i]   = tbl[i].mism;  exp_sum   += tbl[i].mism;
    end
    pulse_start_a();
    drive_a(10, 1'b0, 1'b0, -1, acc_first, done_at, last_hs);
    check_end_a("t3_table", 10, exp_sum, 1'b0, 1'b0);

    // Sparse tready pattern on instance B, predicted cycle by cycle.
    @(negedge clk);
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    k = 0; beats = 0; fetch = 1'b1;
    for (int c = 0; c < 200 && beats < 10; c++) begin
      @(negedge clk);
      b_if.tvalid = 1'b1;
      b_if.tdata  = base_d[beats];
      b_if.tlast  = base_l[beats];
      if (fetch) begin
        check("t4_tready_fetch", 64'(b_if.tready), 64'd0);
        fetch = 1'b0;
      end else begin
        exp_r = PAT_B[k % 8];
        k++;
        check("t4_tready_accept", 64'(b_if.tready), 64'(exp_r));
        if (exp_r) begin
          beats++;
          fetch = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    b_if.tvalid = 1'b0;
    check("t4_done", 64'(b_done), 64'd1);
    check("t4_pass", 64'(b_pass), 64'd1);
    check("t4_beat_cnt", 64'(b_beat), 64'd10);
    check("t4_err_cnt", 64'(b_err), 64'd0);

    // Timeout: tvalid held low after 4 beats; one FETCH cycle then 15 ACCEPT cycles.
    load_base();
    pulse_start_a();
    drive_a(4, 1'b0, 1'b0, -1, acc_first, done_at, last_hs);
    check_end_a("t5", 4, 0, 1'b0, 1'b1);
    check("t5_cycles_after_4th_hs", 64'(done_at - last_hs), 64'd17);

    // Reset mid-run right after beat 5, then a clean run.
    load_base();
    pulse_start_a();
    drive_a(5, 1'b1, 1'b0, -1, acc_first, done_at, last_hs);
    check("t6_busy_before_reset", 64'(a_busy), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_a("t6_reset");
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start_a();
    check("t6_rom_addr_restart", 64'(a_addr), 64'd0);
    drive_a(10, 1'b0, 1'b0, -1, acc_first, done_at, last_hs);
    check_end_a("t6", 10, 0, 1'b1, 1'b0);

    // Start pulsed mid-run (after the beat-7 error) must not restart the run.
    load_base();
    tx_d[3] = 32'h3F80_0001; exp_m[3] = 1;
    tx_l[7] = 1'b0;          exp_m[7] = 1;
    pulse_start_a();
    drive_a(10, 1'b0, 1'b0, 17, acc_first, done_at, last_hs);
    check_end_a("t7", 10, 2, 1'b0, 1'b0);
    check("t7_accept_to_done_cycles", 64'(done_at - acc_first + 1), 64'd20);

    // 300 forced mismatches on instance C: err_cnt saturates at 255.
    @(negedge clk);
    c_start = 1'b1;
    @(posedge clk); #1;
    c_start = 1'b0;
    beats = 0;
    for (int c = 0; c < 2000 && !c_done; c++) begin
      @(negedge clk);
      c_if.tvalid = 1'b1;
      c_if.tdata  = rom_c_word(9'(beats)) ^ 32'h1;
      c_if.tlast  = (beats == 299);
      hs = c_if.tvalid && c_if.tready;
      @(posedge clk); #1;
      if (hs) begin
        beats++;
        if (beats % 50 == 0 || (beats >= 254 && beats <= 256))
          check("t8_err_cnt_step", 64'(c_err), 64'((beats > 255) ? 255 : beats));
      end
    end
    c_if.tvalid = 1'b0;
    check("t8_done", 64'(c_done), 64'd1);
    check("t8_beat_cnt", 64'(c_beat), 64'd300);
    check("t8_err_cnt_sat", 64'(c_err), 64'd255);
    check("t8_pass", 64'(c_pass), 64'd0);
    check("t8_timeout", 64'(c_to), 64'd0);

    // Randomized runs against the reference mismatch rule.
    for (int r = 0; r < 20; r++) begin
      exp_sum = 0;
      for (int i = 0; i < 10; i++) begin
        rom_a_d[i] = rand_fp();
        rom_a_l[i] = (i == 9) || ($urandom_range(3, 0) == 0);
        case ($urandom_range(5, 0))
          0, 1, 2: tx_d[i] = rom_a_d[i];
          3:       tx_d[i] = rom_a_d[i] ^ (32'h1 << $urandom_range(31, 0));
          4:       tx_d[i] = rom_a_d[i] ^ 32'h8000_0000;
          default: tx_d[i] = 32'h7FC0_0000 | 32'($urandom_range(255, 0));
        endcase
        tx_l[i]  = rom_a_l[i] ^ ($urandom_range(7, 0) == 0);
        exp_m[i] = ref_mismatch(rom_a_d[i], rom_a_l[i], tx_d[i], tx_l[i]);
        exp_sum += exp_m[i];
      end
      pulse_start_a();
      drive_a(10, 1'b0, 1'b1, -1, acc_first, done_at, last_hs);
      check_end_a("t9_rand", 10, exp_sum, exp_sum == 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
